axi_stream_header_arbiter: RTL and testbench

- Shares the single header-insert channel (valid_insert/data_insert/keep_insert/byte_insert_cnt/ready_insert) of axi_stream_insert_header among NUM_SRC header requesters.
- Round-robin arbitration, locked per packet: after a header is granted, no new header is issued until the payload's last beat leaves the insert block's output.
- Sits directly in front of the insert block's header port and watches its output handshake.

---
 rtl/axi_stream_pkg.sv | 26 ++
 rtl/axi_stream_header_arbiter_rr_select.sv | 44 ++++
 rtl/axi_stream_header_arbiter.sv | 150 +++++++++++++++
 tb/tb_axi_stream_header_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_pkg.sv
// ---------------------------------------------------------------------------
// axi_stream_pkg
// Shared definitions for the AXI-Stream header insertion blocks.
//   - Default data/keep/byte-count widths.
//   - Header arbiter state encoding.
//   - Header bundle struct {data, keep, byte_cnt} at the default widths.
// ---------------------------------------------------------------------------
package axi_stream_pkg;

  localparam int AXIS_DATA_WD      = 32;
  localparam int AXIS_DATA_BYTE_WD = AXIS_DATA_WD / 8;
  localparam int AXIS_BYTE_CNT_WD  = $clog2(AXIS_DATA_BYTE_WD);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_EOP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [AXIS_DATA_WD-1:0]      data;
    logic [AXIS_DATA_BYTE_WD-1:0] keep;
    logic [AXIS_BYTE_CNT_WD-1:0]  byte_cnt;
  } axis_hdr_t;

endpackage : axi_stream_pkg

// File: rtl/axi_stream_header_arbiter_rr_select.sv
// ---------------------------------------------------------------------------
// rr_select
// Combinational round-robin picker. Searches req upward starting one above
// ptr, wrapping modulo N, and returns the first requester found.
// Ports:
//   req        in   N       request vector
//   ptr        in   PTR_WD  index of the most recently served requester
//   gnt_onehot out  N       one-hot grant (zero when nothing requests)
//   gnt_idx    out  PTR_WD  index of the granted requester (0 when none)
//   any        out  1       at least one request is present
// ---------------------------------------------------------------------------
module rr_select #(
  parameter int N      = 4,
  parameter int PTR_WD = $clog2(N)
) (
  input  logic [N-1:0]      req,
  input  logic [PTR_WD-1:0] ptr,
  output logic [N-1:0]      gnt_onehot,
  output logic [PTR_WD-1:0] gnt_idx,
  output logic              any
);

  // Rotating priority search; the first hit starting at ptr+1 wins.
  always_comb begin
    int                cand;
    logic [PTR_WD-1:0] cand_idx;
    cand       = 0;
    cand_idx   = '0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int off = 1; off <= N; off++) begin
      cand     = (int'(ptr) + off) % N;
      cand_idx = cand[PTR_WD-1:0];
      if (!any && req[cand_idx]) begin
        any                  = 1'b1;
        gnt_idx              = cand_idx;
        gnt_onehot[cand_idx] = 1'b1;
      end else begin
      end
    end
  end

endmodule : rr_select

// File: rtl/axi_stream_header_arbiter.sv
// ---------------------------------------------------------------------------
// axi_stream_header_arbiter
// Shares the header-insert port of axi_stream_insert_header among NUM_SRC
// requesters. Round-robin, locked per packet: once a header is handed over,
// no new header is issued until the payload's last beat leaves the insert
// block (observed through the mon_* taps).
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   src_valid/src_ready      per-source header handshake (ready one-hot/zero)
//   src_data/keep/byte_cnt   per-source header fields, source i at slot i
//   valid_insert/ready_insert header handshake towards the insert block
//   data/keep_insert, byte_insert_cnt  granted header fields
//   mon_valid/ready/last     taps of the insert block's output handshake
//   grant_id                 current or last granted source
//   busy                     header outstanding or packet in flight
//   err_stray_eop            sticky: end-of-packet seen while not waiting
// ---------------------------------------------------------------------------
module axi_stream_header_arbiter
  import axi_stream_pkg::*;
#(
  parameter int DATA_WD      = AXIS_DATA_WD,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_SRC      = 4,
  parameter int SRC_ID_WD    = $clog2(NUM_SRC)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SRC-1:0]              src_valid,
  input  logic [NUM_SRC*DATA_WD-1:0]      src_data,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] src_keep,
  input  logic [NUM_SRC*BYTE_CNT_WD-1:0]  src_byte_cnt,
  output logic [NUM_SRC-1:0]              src_ready,
  output logic                            valid_insert,
  output logic [DATA_WD-1:0]              data_insert,
  output logic [DATA_BYTE_WD-1:0]         keep_insert,
  output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
  input  logic                            ready_insert,
  input  logic                            mon_valid,
  input  logic                            mon_ready,
  input  logic                            mon_last,
  output logic [SRC_ID_WD-1:0]            grant_id,
  output logic                            busy,
  output logic                            err_stray_eop
);

  arb_state_e               state_r;
  logic [SRC_ID_WD-1:0]     rr_ptr_r;
  logic [NUM_SRC-1:0]       sel_onehot_s;
  logic [SRC_ID_WD-1:0]     sel_idx_s;
  logic                     sel_any_s;
  logic [DATA_WD-1:0]       hdr_data_s;
  logic [DATA_BYTE_WD-1:0]  hdr_keep_s;
  logic [BYTE_CNT_WD-1:0]   hdr_cnt_s;
  logic                     eop_s;
  logic                     stray_eop_s;

  rr_select #(
    .N      (NUM_SRC),
    .PTR_WD (SRC_ID_WD)
  ) u_rr_select (
    .req        (src_valid),
    .ptr        (rr_ptr_r),
    .gnt_onehot (sel_onehot_s),
    .gnt_idx    (sel_idx_s),
    .any        (sel_any_s)
  );

  assign eop_s       = mon_valid & mon_ready & mon_last;
  // Any end-of-packet outside WAIT_EOP is unexpected, including one that
  // coincides with the header handshake in SEND.
  assign stray_eop_s = eop_s & (state_r != WAIT_EOP);

  // Accept offered only in IDLE and only to the picked source.
  always_comb begin
    src_ready = '0;
    if (state_r == IDLE) begin
      src_ready = sel_onehot_s;
    end else begin
      src_ready = '0;
    end
  end

  // One-hot mux of the picked source's header fields.
  always_comb begin
    hdr_data_s = '0;
    hdr_keep_s = '0;
    hdr_cnt_s  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_onehot_s[i]) begin
        hdr_data_s = src_data[i*DATA_WD +: DATA_WD];
        hdr_keep_s = src_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        hdr_cnt_s  = src_byte_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
      end else begin
      end
    end
  end

  // Arbitration FSM with registered insert-port and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      rr_ptr_r        <= SRC_ID_WD'(NUM_SRC - 1);
      valid_insert    <= 1'b0;
      data_insert     <= '0;
      keep_insert     <= '0;
      byte_insert_cnt <= '0;
      grant_id        <= '0;
      busy            <= 1'b0;
      err_stray_eop   <= 1'b0;
    end else begin
      if (stray_eop_s) begin
        err_stray_eop <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          // src_ready equals the pick here, so a pick is a handshake.
          if (sel_any_s) begin
            data_insert     <= hdr_data_s;
            keep_insert     <= hdr_keep_s;
            byte_insert_cnt <= hdr_cnt_s;
            grant_id        <= sel_idx_s;
            rr_ptr_r        <= sel_idx_s;
            valid_insert    <= 1'b1;
            busy            <= 1'b1;
            state_r         <= SEND;
          end
        end
        SEND: begin
          if (ready_insert) begin
            valid_insert <= 1'b0;
            state_r      <= WAIT_EOP;
          end
        end
        WAIT_EOP: begin
          if (eop_s) begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          valid_insert <= 1'b0;
          busy         <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

endmodule : axi_stream_header_arbiter

// File: tb/tb_axi_stream_header_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_stream_header_arbiter
// Directed bench with a transaction-level model of the arbiter: a header is
// either "pending" at the insert port, a packet is "locked" in flight, or the
// port is free and the next requester is found by rotating search.
// ---------------------------------------------------------------------------
module tb_axi_stream_header_arbiter;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 2;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NS-1:0]     src_valid = '0;
  logic [NS*DW-1:0]  src_data = '0;
  logic [NS*BW-1:0]  src_keep = '0;
  logic [NS*CW-1:0]  src_byte_cnt = '0;
  logic [NS-1:0]     src_ready;
  logic              valid_insert;
  logic [DW-1:0]     data_insert;
  logic [BW-1:0]     keep_insert;
  logic [CW-1:0]     byte_insert_cnt;
  logic              ready_insert = 1'b1;
  logic              mon_valid = 1'b0;
  logic              mon_ready = 1'b0;
  logic              mon_last = 1'b0;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic              err_stray_eop;

  int checks = 0;
  int failures = 0;

  axi_stream_header_arbiter #(
    .DATA_WD (DW), .DATA_BYTE_WD (BW), .BYTE_CNT_WD (CW),
    .NUM_SRC (NS), .SRC_ID_WD (IW)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .src_valid (src_valid), .src_data (src_data), .src_keep (src_keep),
    .src_byte_cnt (src_byte_cnt), .src_ready (src_ready),
    .valid_insert (valid_insert), .data_insert (data_insert),
    .keep_insert (keep_insert), .byte_insert_cnt (byte_insert_cnt),
    .ready_insert (ready_insert),
    .mon_valid (mon_valid), .mon_ready (mon_ready), .mon_last (mon_last),
    .grant_id (grant_id), .busy (busy), .err_stray_eop (err_stray_eop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int rr_pick(input int last, input logic [NS-1:0] req);
    for (int k = 1; k <= NS; k++) begin
      if (req[(last + k) % NS]) return (last + k) % NS;
    end
    return -1;
  endfunction

  bit            m_pending = 1'b0;
  bit            m_locked  = 1'b0;
  bit            m_err     = 1'b0;
  int            m_last    = NS - 1;
  logic [IW-1:0] m_gid     = '0;
  logic [DW-1:0] m_data    = '0;
  logic [BW-1:0] m_keep    = '0;
  logic [CW-1:0] m_cnt     = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending <= 1'b0; m_locked <= 1'b0; m_err <= 1'b0; m_last <= NS - 1;
      m_gid <= '0; m_data <= '0; m_keep <= '0; m_cnt <= '0;
    end else if (m_pending) begin
      if (mon_valid && mon_ready && mon_last) m_err <= 1'b1;
      if (ready_insert) begin
        m_pending <= 1'b0;
        m_locked  <= 1'b1;
      end
    end else if (m_locked) begin
      if (mon_valid && mon_ready && mon_last) m_locked <= 1'b0;
    end else begin
      if (mon_valid && mon_ready && mon_last) m_err <= 1'b1;
      if (rr_pick(m_last, src_valid) >= 0) begin
        m_pending <= 1'b1;
        m_last    <= rr_pick(m_last, src_valid);
        m_gid     <= IW'(rr_pick(m_last, src_valid));
        m_data    <= src_data[rr_pick(m_last, src_valid)*DW +: DW];
        m_keep    <= src_keep[rr_pick(m_last, src_valid)*BW +: BW];
        m_cnt     <= src_byte_cnt[rr_pick(m_last, src_valid)*CW +: CW];
      end
    end
  end

  // compare process: every cycle on the falling edge
  always @(negedge clk) begin
    logic [NS-1:0] exp_rdy;
    exp_rdy = '0;
    if (!m_pending && !m_locked && rr_pick(m_last, src_valid) >= 0)
      exp_rdy[rr_pick(m_last, src_valid)] = 1'b1;
    chk("m_src_ready", src_ready, exp_rdy);
    chk("m_valid_insert", valid_insert, m_pending);
    chk("m_busy", busy, m_pending | m_locked);
    chk("m_grant_id", grant_id, m_gid);
    chk("m_err", err_stray_eop, m_err);
    chk("m_data", data_insert, m_data);
    chk("m_keep", keep_insert, m_keep);
    chk("m_cnt", byte_insert_cnt, m_cnt);
  end

  // ---------------- handshake logging ----------------
  int            cyc = 0;
  logic [NS-1:0] hs_r = '0;
  bit            ins_r = 1'b0;
  int            grant_q[$];
  int            gcyc_q[$];
  bit            cont = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    hs_r  = rst_n ? (src_valid & src_ready) : '0;
    ins_r = rst_n && valid_insert && ready_insert;
    for (int i = 0; i < NS; i++) begin
      if (hs_r[i]) begin
        grant_q.push_back(i);
        gcyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_src(input int i, input logic [DW-1:0] d, input logic [BW-1:0] k,
                         input logic [CW-1:0] c);
    src_data[i*DW +: DW]     = d;
    src_keep[i*BW +: BW]     = k;
    src_byte_cnt[i*CW +: CW] = c;
  endtask

  // advance one cycle; accepted sources either drop valid or offer a new header
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (hs_r[i]) begin
        if (cont) src_data[i*DW +: DW] = src_data[i*DW +: DW] + 32'd1;
        else src_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_grant(output int idx);
    int n;
    n = 0;
    idx = -1;
    do begin
      step();
      n++;
    end while (hs_r == '0 && n < 50);
    if (hs_r == '0) begin
      checks++; failures++;
      $display("FAIL grant_timeout: got none expected a grant within 50 cycles");
    end else begin
      for (int i = 0; i < NS; i++) if (hs_r[i]) idx = i;
    end
  endtask

  task automatic wait_ins();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!ins_r && n < 50);
    if (!ins_r) begin
      checks++; failures++;
      $display("FAIL insert_timeout: got none expected header accept within 50 cycles");
    end
  endtask

  task automatic payload(input int beats);
    mon_valid = 1'b1;
    mon_ready = 1'b1;
    for (int b = 0; b < beats; b++) begin
      mon_last = (b == beats - 1);
      step();
    end
    mon_valid = 1'b0;
    mon_ready = 1'b0;
    mon_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int idx;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_valid_insert", valid_insert, 1'b0);
    chk("rst_grant_id", grant_id, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_stray_eop, 1'b0);
    chk("rst_data", data_insert, 32'h0);

    // all four sources continuously, 3-beat packets
    for (int i = 0; i < NS; i++) set_src(i, 32'h1000_0000 * (i + 1), 4'b1111, 2'(i));
    grant_q.delete();
    gcyc_q.delete();
    cont = 1'b1;
    src_valid = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      wait_grant(idx);
      if (p == 4) begin
        cont = 1'b0;
        src_valid = '0;
      end
      wait_ins();
      payload(3);
    end
    chk("rr_count", grant_q.size(), 5);
    for (int p = 0; p < 5 && p < grant_q.size(); p++) chk("rr_order", grant_q[p], exp_order[p]);
    for (int p = 0; p < 4 && p + 1 < gcyc_q.size(); p++)
      chk("rr_gap", gcyc_q[p+1] - gcyc_q[p], 5);

    // single source 2
    set_src(2, 32'hA5A5_0001, 4'b0111, 2'd2);
    src_valid = 4'b0100;
    #1;
    chk("t1_src_ready", src_ready, 4'b0100);
    wait_grant(idx);
    chk("t1_idx", idx, 2);
    chk("t1_valid", valid_insert, 1'b1);
    chk("t1_data", data_insert, 32'hA5A5_0001);
    chk("t1_keep", keep_insert, 4'b0111);
    chk("t1_cnt", byte_insert_cnt, 2'd2);
    chk("t1_gid", grant_id, 2'd2);
    chk("t1_busy", busy, 1'b1);
    wait_ins();
    payload(2);

    // ready_insert stalled 5 cycles in SEND; src 0 waiting meanwhile
    set_src(3, 32'hDEAD_BEEF, 4'b1111, 2'd3);
    set_src(0, 32'h0000_00C0, 4'b0001, 2'd1);
    ready_insert = 1'b0;
    src_valid = 4'b1001;
    wait_grant(idx);
    chk("t3_idx", idx, 3);
    for (int c = 0; c < 5; c++) begin
      chk("t3_valid_hold", valid_insert, 1'b1);
      chk("t3_data_hold", data_insert, 32'hDEAD_BEEF);
      chk("t3_src_ready0", src_ready, 4'b0000);
      step();
    end
    ready_insert = 1'b1;
    wait_ins();
    payload(2);

    // source 0 packet; source 1 requests during WAIT_EOP
    wait_grant(idx);
    chk("t4_idx0", idx, 0);
    wait_ins();
    set_src(1, 32'h1111_2222, 4'b0011, 2'd1);
    src_valid[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("t4_locked_ready", src_ready, 4'b0000);
      step();
    end
    mon_valid = 1'b1; mon_ready = 1'b1; mon_last = 1'b1;
    step();
    mon_valid = 1'b0; mon_ready = 1'b0; mon_last = 1'b0;
    chk("t4_ready_after_eop", src_ready, 4'b0010);
    chk("t4_busy_idle", busy, 1'b0);
    wait_grant(idx);
    chk("t4_idx1", idx, 1);
    chk("t4_data", data_insert, 32'h1111_2222);
    wait_ins();
    payload(1);

    // stray end-of-packet while idle
    mon_valid = 1'b1; mon_ready = 1'b1; mon_last = 1'b1;
    step();
    mon_valid = 1'b0; mon_ready = 1'b0; mon_last = 1'b0;
    chk("t5_err_set", err_stray_eop, 1'b1);
    chk("t5_busy", busy, 1'b0);
    set_src(2, 32'h2222_0005, 4'b1111, 2'd0);
    src_valid[2] = 1'b1;
    wait_grant(idx);
    chk("t5_idx", idx, 2);
    wait_ins();
    chk("t5_err_sticky", err_stray_eop, 1'b1);

    // reset in WAIT_EOP; afterwards source 0 wins over 3 despite last grant 2
    step();
    chk("t6_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", valid_insert, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_gid", grant_id, 2'd0);
    chk("t6_rst_err", err_stray_eop, 1'b0);
    chk("t6_rst_data", data_insert, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NS; i++) set_src(i, 32'h6000_0000 + i, 4'b1111, 2'd3);
    src_valid = 4'b1111;
    wait_grant(idx);
    chk("t6_first_after_rst", idx, 0);
    chk("t6_gid", grant_id, 2'd0);
    src_valid = '0;
    wait_ins();
    payload(1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_axi_stream_header_arbiter
